// File: rtl/axi_top.sv
// AXI3 memory-mapped slave: word-addressed 32-bit RAM behind independent write
// (AW/W/B) and read (AR/R) channels, FIXED/INCR/WRAP bursts with byte strobes.
module axi_top #(
    parameter int MEM_WORDS = 256,
    parameter int B_DEPTH   = 4
) (
    input  logic        a_clk,
    input  logic        a_reset,
    input  logic [3:0]  aw_id,
    input  logic [31:0] aw_addr,
    input  logic [3:0]  aw_len,
    input  logic [2:0]  aw_size,
    input  logic [1:0]  aw_burst,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  logic [3:0]  w_id,
    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    input  logic        w_last,
    input  logic        w_valid,
    output logic        w_ready,
    output logic [3:0]  b_id,
    output logic [1:0]  b_resp,
    output logic        b_valid,
    input  logic        b_ready,
    input  logic [3:0]  ar_id,
    input  logic [31:0] ar_addr,
    input  logic [3:0]  ar_len,
    input  logic [2:0]  ar_size,
    input  logic [1:0]  ar_burst,
    input  logic        ar_valid,
    output logic        ar_ready,
    output logic [3:0]  r_id,
    output logic [31:0] r_data,
    output logic [1:0]  r_resp,
    output logic        r_last,
    output logic        r_valid,
    input  logic        r_ready
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int BP_W  = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
    localparam int BC_W  = $clog2(B_DEPTH + 1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_e;
    typedef enum logic {R_IDLE, R_DATA} rState_e;

    // Address of the following beat; a WRAP with an illegal length behaves as INCR.
    function automatic logic [31:0] nextAddr(input logic [31:0] addr, input logic [3:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
        logic [1:0]  shift;
        logic [31:0] inc;
        logic [31:0] mask;
        logic        wrapLen;
        shift   = (size > 3'd2) ? 2'd2 : size[1:0];
        inc     = addr + (32'd1 << shift);
        mask    = (({28'd0, len} + 32'd1) << shift) - 32'd1;
        wrapLen = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        if (burst == 2'd0)
            nextAddr = addr;
        else if (burst == 2'd2 && wrapLen)
            nextAddr = (addr & ~mask) | (inc & mask);
        else
            nextAddr = inc;
    endfunction

    logic [31:0] r_mem [MEM_WORDS];

    wState_e     r_wState, w_wNext;
    logic [3:0]  r_awId;
    logic [31:0] r_wAddr;
    logic [3:0]  r_awLen;
    logic [2:0]  r_awSize;
    logic [1:0]  r_awBurst;
    logic [3:0]  r_wBeat;
    logic        r_wErr;
    logic        w_awFire, w_wFire, w_wLastBeat, w_bPush, w_bPop, w_bFull;
    logic [IDX_W-1:0] w_wIdx;

    logic [3:0]      r_bIdQ   [B_DEPTH];
    logic [1:0]      r_bRespQ [B_DEPTH];
    logic [BP_W-1:0] r_bHead, r_bTail;
    logic [BC_W-1:0] r_bCount;

    rState_e     r_rState, w_rNext;
    logic [3:0]  r_arId;
    logic [31:0] r_rAddr;
    logic [3:0]  r_arLen;
    logic [2:0]  r_arSize;
    logic [1:0]  r_arBurst;
    logic [3:0]  r_rBeat;
    logic        r_rErr;
    logic        w_arFire, w_rFire, w_rLastBeat;
    logic [31:0] w_rNextAddr;

    assign w_awFire    = aw_valid && aw_ready;
    assign w_wFire     = w_valid && w_ready;
    assign w_wLastBeat = (r_wBeat == r_awLen);
    assign w_wIdx      = r_wAddr[IDX_W+1:2];
    assign w_bFull     = (r_bCount == BC_W'(B_DEPTH));
    assign w_bPop      = b_valid && b_ready;

    always_ff @(posedge a_clk or posedge a_reset) begin
        if (a_reset) r_wState <= W_IDLE;
        else         r_wState <= w_wNext;
    end

    always_comb begin
        w_wNext = r_wState;
        case (r_wState)
            W_IDLE:  if (w_awFire) w_wNext = W_DATA;
            W_DATA:  if (w_wFire && w_wLastBeat) w_wNext = W_RESP;
            W_RESP:  w_wNext = W_IDLE;
            default: w_wNext = W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        w_bPush  = 1'b0;
        case (r_wState)
            W_IDLE:  aw_ready = !w_bFull;
            W_DATA:  w_ready  = 1'b1;
            W_RESP:  w_bPush  = 1'b1;
            default: ;
        endcase
    end

    // The error flag accumulates across beats so one bad beat poisons the whole burst.
    always_ff @(posedge a_clk or posedge a_reset) begin
        if (a_reset) begin
            r_awId    <= 4'd0;
            r_wAddr   <= 32'd0;
            r_awLen   <= 4'd0;
            r_awSize  <= 3'd0;
            r_awBurst <= 2'd0;
            r_wBeat   <= 4'd0;
            r_wErr    <= 1'b0;
        end else if (w_awFire) begin
            r_awId    <= aw_id;
            r_wAddr   <= aw_addr;
            r_awLen   <= aw_len;
            r_awSize  <= aw_size;
            r_awBurst <= aw_burst;
            r_wBeat   <= 4'd0;
            r_wErr    <= (aw_size > 3'd2) || (aw_burst == 2'd3);
        end else if (w_wFire) begin
            r_wAddr <= nextAddr(r_wAddr, r_awLen, r_awSize, r_awBurst);
            r_wBeat <= r_wBeat + 4'd1;
            if ((w_last != w_wLastBeat) || (w_id != r_awId))
                r_wErr <= 1'b1;
        end
    end

    always_ff @(posedge a_clk) begin
        if (w_wFire) begin
            for (int i = 0; i < 4; i++)
                if (w_strb[i]) r_mem[w_wIdx][8*i +: 8] <= w_data[8*i +: 8];
        end
        if (w_bPush) begin
            r_bIdQ[r_bTail]   <= r_awId;
            r_bRespQ[r_bTail] <= r_wErr ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge a_clk or posedge a_reset) begin
        if (a_reset) begin
            r_bHead  <= '0;
            r_bTail  <= '0;
            r_bCount <= '0;
        end else begin
            if (w_bPush)
                r_bTail <= (r_bTail == BP_W'(B_DEPTH - 1)) ? '0 : r_bTail + 1'b1;
            if (w_bPop)
                r_bHead <= (r_bHead == BP_W'(B_DEPTH - 1)) ? '0 : r_bHead + 1'b1;
            if (w_bPush && !w_bPop)
                r_bCount <= r_bCount + 1'b1;
            else if (w_bPop && !w_bPush)
                r_bCount <= r_bCount - 1'b1;
        end
    end

    assign b_valid = (r_bCount != '0);
    assign b_id    = b_valid ? r_bIdQ[r_bHead]   : 4'd0;
    assign b_resp  = b_valid ? r_bRespQ[r_bHead] : 2'b00;

    assign w_arFire    = ar_valid && ar_ready;
    assign w_rFire     = r_valid && r_ready;
    assign w_rLastBeat = (r_rBeat == r_arLen);
    assign w_rNextAddr = nextAddr(r_rAddr, r_arLen, r_arSize, r_arBurst);

    always_ff @(posedge a_clk or posedge a_reset) begin
        if (a_reset) r_rState <= R_IDLE;
        else         r_rState <= w_rNext;
    end

    always_comb begin
        w_rNext = r_rState;
        case (r_rState)
            R_IDLE:  if (w_arFire) w_rNext = R_DATA;
            R_DATA:  if (w_rFire && w_rLastBeat) w_rNext = R_IDLE;
            default: w_rNext = R_IDLE;
        endcase
    end

    always_comb begin
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        case (r_rState)
            R_IDLE:  ar_ready = 1'b1;
            R_DATA:  r_valid  = 1'b1;
            default: ;
        endcase
        r_last = r_valid && w_rLastBeat;
        r_resp = (r_valid && r_rErr) ? 2'b10 : 2'b00;
    end

    // r_data samples the RAM before this edge's write lands, giving read-before-write.
    always_ff @(posedge a_clk or posedge a_reset) begin
        if (a_reset) begin
            r_arId    <= 4'd0;
            r_rAddr   <= 32'd0;
            r_arLen   <= 4'd0;
            r_arSize  <= 3'd0;
            r_arBurst <= 2'd0;
            r_rBeat   <= 4'd0;
            r_rErr    <= 1'b0;
            r_data    <= 32'd0;
        end else if (w_arFire) begin
            r_arId    <= ar_id;
            r_rAddr   <= ar_addr;
            r_arLen   <= ar_len;
            r_arSize  <= ar_size;
            r_arBurst <= ar_burst;
            r_rBeat   <= 4'd0;
            r_rErr    <= (ar_size > 3'd2) || (ar_burst == 2'd3);
            r_data    <= r_mem[ar_addr[IDX_W+1:2]];
        end else if (w_rFire && !w_rLastBeat) begin
            r_rAddr <= w_rNextAddr;
            r_rBeat <= r_rBeat + 4'd1;
            r_data  <= r_mem[w_rNextAddr[IDX_W+1:2]];
        end
    end

    assign r_id = r_arId;

endmodule

// File: tb/tb_axi_top.sv
// Self-checking bench for axi_top: directed scenarios plus randomized bursts
// compared against a byte-level memory model and a burst address model.
module tb_axi_top;

    localparam int MEM_WORDS = 256;
    localparam int B_DEPTH   = 4;

    logic        a_clk = 1'b0;
    logic        a_reset = 1'b1;
    logic [3:0]  aw_id = '0;
    logic [31:0] aw_addr = '0;
    logic [3:0]  aw_len = '0;
    logic [2:0]  aw_size = '0;
    logic [1:0]  aw_burst = '0;
    logic        aw_valid = 1'b0;
    logic        aw_ready;
    logic [3:0]  w_id = '0;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        w_last = 1'b0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic [3:0]  ar_id = '0;
    logic [31:0] ar_addr = '0;
    logic [3:0]  ar_len = '0;
    logic [2:0]  ar_size = '0;
    logic [1:0]  ar_burst = '0;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_valid;
    logic        r_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] refMem  [MEM_WORDS];
    logic [31:0] wrData  [16];
    logic [3:0]  wrStrb  [16];
    logic [31:0] capData [16];
    logic        capLast [16];
    logic [1:0]  capResp [16];
    logic [3:0]  capId   [16];

    always #5 a_clk = ~a_clk;

    axi_top #(.MEM_WORDS(MEM_WORDS), .B_DEPTH(B_DEPTH)) dut (
        .a_clk(a_clk), .a_reset(a_reset),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
        .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_id(w_id), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    // Beat i address: wrap is an offset taken modulo the wrap window above its aligned base.
    function automatic logic [31:0] beatAddr(input logic [31:0] addr, input logic [3:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int i);
        logic [31:0] step, beats, bound, lower;
        step  = (size > 3'd2) ? 32'd4 : (32'd1 << size);
        beats = 32'(len) + 32'd1;
        if (burst == 2'd0) return addr;
        if (burst == 2'd2 && (beats == 32'd2 || beats == 32'd4 || beats == 32'd8 || beats == 32'd16)) begin
            bound = beats * step;
            lower = (addr / bound) * bound;
            return lower + (((addr - lower) + 32'(i) * step) % bound);
        end
        return addr + 32'(i) * step;
    endfunction

    function automatic int wordIdx(input logic [31:0] a);
        return int'((a >> 2) & 32'(MEM_WORDS - 1));
    endfunction

    function automatic logic [1:0] expResp(input logic [2:0] size, input logic [1:0] burst, input logic bad);
        return (size > 3'd2 || burst == 2'd3 || bad) ? 2'b10 : 2'b00;
    endfunction

    task automatic modelWrite(input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        for (int i = 0; i <= int'(len); i++) begin
            int idx = wordIdx(beatAddr(addr, len, size, burst, i));
            for (int b = 0; b < 4; b++)
                if (wrStrb[i][b]) refMem[idx][8*b +: 8] = wrData[i][8*b +: 8];
        end
    endtask

    task automatic sendAw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
        while (aw_ready !== 1'b1 && n < 200) begin @(negedge a_clk); n++; end
        if (aw_ready !== 1'b1) begin
            checks++; errors++;
            $display("[TB] FAIL aw_timeout: aw_ready=%b required 1", aw_ready);
        end
        @(negedge a_clk);
        aw_valid = 1'b0;
    endtask

    task automatic sendW(input logic [3:0] id, input logic [3:0] len, input int badLast, input int badId);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            w_id    = (i == badId) ? (id ^ 4'd1) : id;
            w_data  = wrData[i];
            w_strb  = wrStrb[i];
            w_last  = (i == int'(len)) ^ (i == badLast);
            w_valid = 1'b1;
            while (w_ready !== 1'b1 && n < 200) begin @(negedge a_clk); n++; end
            if (w_ready !== 1'b1) begin
                checks++; errors++;
                $display("[TB] FAIL w_timeout: w_ready=%b required 1", w_ready);
            end
            @(negedge a_clk);
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic doWrite(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int badLast, input int badId);
        sendAw(id, addr, len, size, burst);
        sendW(id, len, badLast, badId);
        modelWrite(addr, len, size, burst);
    endtask

    task automatic getB(output logic [3:0] id, output logic [1:0] resp);
        int n = 0;
        b_ready = 1'b1;
        while (b_valid !== 1'b1 && n < 200) begin @(negedge a_clk); n++; end
        if (b_valid !== 1'b1) begin
            checks++; errors++;
            $display("[TB] FAIL b_timeout: b_valid=%b required 1", b_valid);
        end
        id = b_id;
        resp = b_resp;
        @(negedge a_clk);
        b_ready = 1'b0;
    endtask

    task automatic sendAr(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
        while (ar_ready !== 1'b1 && n < 200) begin @(negedge a_clk); n++; end
        if (ar_ready !== 1'b1) begin
            checks++; errors++;
            $display("[TB] FAIL ar_timeout: ar_ready=%b required 1", ar_ready);
        end
        @(negedge a_clk);
        ar_valid = 1'b0;
    endtask

    task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        sendAr(id, addr, len, size, burst);
        r_ready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            while (r_valid !== 1'b1 && n < 200) begin @(negedge a_clk); n++; end
            if (r_valid !== 1'b1) begin
                checks++; errors++;
                $display("[TB] FAIL r_timeout: r_valid=%b required 1", r_valid);
            end
            capData[i] = r_data; capLast[i] = r_last; capResp[i] = r_resp; capId[i] = r_id;
            @(negedge a_clk);
        end
        r_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (aw_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_aw_ready: got %b want 1", aw_ready); end
        checks++; if (w_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_w_ready: got %b want 0", w_ready); end
        checks++; if (b_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_b_valid: got %b want 0", b_valid); end
        checks++; if ({b_id, b_resp} !== 6'd0) begin errors++; $display("[TB] FAIL rst_b_fields: got %h want 0", {b_id, b_resp}); end
        checks++; if (ar_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ar_ready: got %b want 1", ar_ready); end
        checks++; if (r_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_r_valid: got %b want 0", r_valid); end
        checks++; if (r_data !== 32'd0) begin errors++; $display("[TB] FAIL rst_r_data: got %h want 0", r_data); end
        checks++; if ({r_id, r_resp, r_last} !== 7'd0) begin errors++; $display("[TB] FAIL rst_r_fields: got %h want 0", {r_id, r_resp, r_last}); end
    endtask

    // Gives every RAM word a known value so later reads are fully predictable.
    task automatic test_fill();
        logic [3:0] id;
        logic [1:0] resp;
        for (int blk = 0; blk < MEM_WORDS / 16; blk++) begin
            for (int i = 0; i < 16; i++) begin wrData[i] = $urandom; wrStrb[i] = 4'hF; end
            doWrite(4'(blk), 32'(blk * 64), 4'd15, 3'd2, 2'd1, -1, -1);
            getB(id, resp);
            checks++;
            if (id !== 4'(blk) || resp !== 2'b00) begin
                errors++; $display("[TB] FAIL fill_b: got id %h resp %b want id %h resp 00", id, resp, 4'(blk));
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] id;
        logic [1:0] resp;
        wrData[0] = 32'hDEADBEEF; wrStrb[0] = 4'hF;
        sendAw(4'd5, 32'h0, 4'd0, 3'd2, 2'd1);
        checks++; if (w_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_w_ready: got %b want 1", w_ready); end
        sendW(4'd5, 4'd0, -1, -1);
        modelWrite(32'h0, 4'd0, 3'd2, 2'd1);
        checks++; if (b_valid !== 1'b0 || aw_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL single_resp_phase: b_valid %b aw_ready %b want 0 0", b_valid, aw_ready); end
        @(negedge a_clk);
        checks++; if (b_valid !== 1'b1 || aw_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL single_b_timing: b_valid %b aw_ready %b want 1 1", b_valid, aw_ready); end
        getB(id, resp);
        checks++; if (id !== 4'd5 || resp !== 2'b00) begin
            errors++; $display("[TB] FAIL single_b: got id %h resp %b want 5 00", id, resp); end
        readBurst(4'd1, 32'h0, 4'd0, 3'd2, 2'd1);
        checks++; if (capData[0] !== 32'hDEADBEEF || capLast[0] !== 1'b1 || capResp[0] !== 2'b00 || capId[0] !== 4'd1) begin
            errors++; $display("[TB] FAIL single_r: got %h last %b resp %b id %h want deadbeef 1 00 1",
                               capData[0], capLast[0], capResp[0], capId[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [3:0]  id;
        logic [1:0]  resp;
        b_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            addrs[k] = $urandom & 32'h3FC;
            wrData[0] = $urandom; wrStrb[0] = 4'hF;
            doWrite(4'(k + 1), addrs[k], 4'd0, 3'd2, 2'd1, -1, -1);
        end
        repeat (3) @(negedge a_clk);
        checks++; if (aw_ready !== 1'b0 || b_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_full: aw_ready %b b_valid %b want 0 1", aw_ready, b_valid); end
        for (int k = 0; k < 4; k++) begin
            getB(id, resp);
            checks++; if (id !== 4'(k + 1) || resp !== 2'b00) begin
                errors++; $display("[TB] FAIL b2b_order%0d: got id %h resp %b want %h 00", k, id, resp, 4'(k + 1)); end
        end
        for (int k = 0; k < 4; k++) begin
            readBurst(4'd2, addrs[k], 4'd0, 3'd2, 2'd1);
            checks++; if (capData[0] !== refMem[wordIdx(addrs[k])]) begin
                errors++; $display("[TB] FAIL b2b_read%0d: got %h want %h", k, capData[0], refMem[wordIdx(addrs[k])]); end
        end
    endtask

    task automatic test_strobe();
        logic [3:0] id;
        logic [1:0] resp;
        wrData[0] = 32'hFFFFFFFF; wrStrb[0] = 4'hF;
        doWrite(4'd3, 32'h20, 4'd0, 3'd2, 2'd1, -1, -1);
        getB(id, resp);
        wrData[0] = 32'h12345678; wrStrb[0] = 4'b0101;
        doWrite(4'd3, 32'h20, 4'd0, 3'd2, 2'd1, -1, -1);
        getB(id, resp);
        readBurst(4'd3, 32'h20, 4'd0, 3'd2, 2'd1);
        checks++; if (capData[0] !== 32'hFF34FF78) begin
            errors++; $display("[TB] FAIL strobe: got %h want ff34ff78", capData[0]); end
    endtask

    task automatic test_incr_wrap();
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [31:0] wrapExp [4];
        wrapExp[0] = 32'd3; wrapExp[1] = 32'd4; wrapExp[2] = 32'd1; wrapExp[3] = 32'd2;
        for (int i = 0; i < 4; i++) begin wrData[i] = 32'(i + 1); wrStrb[i] = 4'hF; end
        doWrite(4'd6, 32'h10, 4'd3, 3'd2, 2'd1, -1, -1);
        getB(id, resp);
        checks++; if (id !== 4'd6 || resp !== 2'b00) begin
            errors++; $display("[TB] FAIL incr_b: got id %h resp %b want 6 00", id, resp); end
        readBurst(4'd7, 32'h10, 4'd3, 3'd2, 2'd1);
        for (int i = 0; i < 4; i++) begin
            checks++; if (capData[i] !== 32'(i + 1) || capLast[i] !== (i == 3) || capId[i] !== 4'd7) begin
                errors++; $display("[TB] FAIL incr_beat%0d: got %h last %b id %h want %h %b 7",
                                   i, capData[i], capLast[i], capId[i], 32'(i + 1), (i == 3)); end
        end
        readBurst(4'd8, 32'h18, 4'd3, 3'd2, 2'd2);
        for (int i = 0; i < 4; i++) begin
            checks++; if (capData[i] !== wrapExp[i] || capLast[i] !== (i == 3)) begin
                errors++; $display("[TB] FAIL wrap_beat%0d: got %h last %b want %h %b",
                                   i, capData[i], capLast[i], wrapExp[i], (i == 3)); end
        end
    endtask

    task automatic test_errors();
        logic [3:0] id;
        logic [1:0] resp;
        for (int i = 0; i < 2; i++) begin wrData[i] = $urandom; wrStrb[i] = 4'hF; end
        doWrite(4'd2, 32'h40, 4'd1, 3'd2, 2'd1, 0, -1);
        getB(id, resp);
        checks++; if (id !== 4'd2 || resp !== 2'b10) begin
            errors++; $display("[TB] FAIL err_early_last: got id %h resp %b want 2 10", id, resp); end
        readBurst(4'd2, 32'h40, 4'd1, 3'd2, 2'd1);
        checks++; if (capData[0] !== refMem[16] || capData[1] !== refMem[17]) begin
            errors++; $display("[TB] FAIL err_data_kept: got %h %h want %h %h", capData[0], capData[1], refMem[16], refMem[17]); end
        doWrite(4'd4, 32'h48, 4'd0, 3'd2, 2'd1, -1, 0);
        getB(id, resp);
        checks++; if (resp !== 2'b10) begin errors++; $display("[TB] FAIL err_wid: got resp %b want 10", resp); end
        doWrite(4'd5, 32'h50, 4'd0, 3'd3, 2'd1, -1, -1);
        getB(id, resp);
        checks++; if (resp !== 2'b10) begin errors++; $display("[TB] FAIL err_wsize: got resp %b want 10", resp); end
        readBurst(4'd9, 32'h40, 4'd2, 3'd2, 2'd3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (capResp[i] !== 2'b10 || capData[i] !== refMem[16 + i]) begin
                errors++; $display("[TB] FAIL err_rburst%0d: got resp %b data %h want 10 %h", i, capResp[i], capData[i], refMem[16 + i]); end
        end
    endtask

    task automatic test_rready_toggle();
        sendAr(4'd9, 32'h10, 4'd3, 3'd2, 2'd1);
        r_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int h = 0; h < 2; h++) begin
                checks++; if (r_valid !== 1'b1 || r_data !== refMem[4 + i] || r_last !== (i == 3)) begin
                    errors++; $display("[TB] FAIL hold_beat%0d: valid %b data %h last %b want 1 %h %b",
                                       i, r_valid, r_data, r_last, refMem[4 + i], (i == 3)); end
                @(negedge a_clk);
            end
            r_ready = 1'b1;
            @(negedge a_clk);
            r_ready = 1'b0;
        end
        checks++; if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL hold_end: r_valid %b ar_ready %b want 0 1", r_valid, ar_ready); end
    endtask

    task automatic test_reset_mid();
        sendAr(4'd3, 32'h0, 4'd7, 3'd2, 2'd1);
        r_ready = 1'b1;
        repeat (2) @(negedge a_clk);
        r_ready = 1'b0;
        #2 a_reset = 1'b1;
        #1;
        checks++; if (r_valid !== 1'b0 || ar_ready !== 1'b1 || r_last !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_read: r_valid %b ar_ready %b r_last %b want 0 1 0", r_valid, ar_ready, r_last); end
        @(negedge a_clk);
        a_reset = 1'b0;
        sendAw(4'd6, 32'h100, 4'd3, 3'd2, 2'd1);
        w_id = 4'd6; w_data = $urandom; w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
        @(negedge a_clk);
        w_valid = 1'b0;
        refMem[wordIdx(32'h100)] = w_data;
        #2 a_reset = 1'b1;
        @(negedge a_clk);
        a_reset = 1'b0;
        b_ready = 1'b0;
        repeat (4) @(negedge a_clk);
        checks++; if (b_valid !== 1'b0 || w_ready !== 1'b0 || aw_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_mid_write: b_valid %b w_ready %b aw_ready %b want 0 0 1", b_valid, w_ready, aw_ready); end
    endtask

    task automatic test_random();
        logic [3:0]  id, len, gotId;
        logic [2:0]  size;
        logic [1:0]  burst, gotResp, eResp;
        logic [31:0] addr, expData;
        int          badLast, badId;
        for (int t = 0; t < 40; t++) begin
            id = 4'($urandom); addr = $urandom; len = 4'($urandom_range(0, 15));
            size = 3'($urandom_range(0, 3)); burst = 2'($urandom_range(0, 3));
            badLast = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
            badId   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
            for (int i = 0; i < 16; i++) begin wrData[i] = $urandom; wrStrb[i] = 4'($urandom); end
            doWrite(id, addr, len, size, burst, badLast, badId);
            getB(gotId, gotResp);
            eResp = expResp(size, burst, (badLast >= 0) || (badId >= 0));
            checks++; if (gotId !== id || gotResp !== eResp) begin
                errors++; $display("[TB] FAIL rand_b%0d: got id %h resp %b want %h %b", t, gotId, gotResp, id, eResp); end
            id = 4'($urandom); len = 4'($urandom_range(0, 15));
            size = 3'($urandom_range(0, 3)); burst = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) addr = $urandom;
            readBurst(id, addr, len, size, burst);
            eResp = expResp(size, burst, 1'b0);
            for (int i = 0; i <= int'(len); i++) begin
                expData = refMem[wordIdx(beatAddr(addr, len, size, burst, i))];
                checks++; if (capData[i] !== expData || capLast[i] !== (i == int'(len)) || capResp[i] !== eResp || capId[i] !== id) begin
                    errors++; $display("[TB] FAIL rand_r%0d_beat%0d: got %h last %b resp %b id %h want %h %b %b %h",
                                       t, i, capData[i], capLast[i], capResp[i], capId[i], expData, (i == int'(len)), eResp, id); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge a_clk);
        test_reset();
        a_reset = 1'b0;
        @(negedge a_clk);
        test_fill();
        test_single();
        test_back_to_back();
        test_strobe();
        test_incr_wrap();
        test_errors();
        test_rready_toggle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
